// File: rtl/cpu_bus_pkg.sv
// ----------------------------------------------------------------------------
// cpu_bus_pkg
// Shared types for the L1-cache to memory-bus path.
//   mem_req_t   : one latched memory command (address, write data, byte
//                 enables, size, read/write)
//   arb_state_t : arbiter FSM states
//   SIZE_WORD   : size encoding for a full 32-bit word
// Addresses are carried at ADDR_W_MAX bits. Narrower users zero-extend
// into the field and slice back out.
// ----------------------------------------------------------------------------
package cpu_bus_pkg;

    localparam int unsigned ADDR_W_MAX = 64;
    localparam logic [1:0]  SIZE_WORD  = 2'b10;

    typedef struct packed {
        logic [ADDR_W_MAX-1:0] addr;
        logic [31:0]           wdata;
        logic [3:0]            wen;
        logic [1:0]            size;
        logic                  rw;
    } mem_req_t;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_grant_sel.sv
// ----------------------------------------------------------------------------
// arb_grant_sel
// Combinational winner selection between the I-side and D-side requests.
// The parent only evaluates the outputs while the bus is idle.
// Ports:
//   i_req, d_req       in   request from I-side / D-side
//   last_grant         in   side granted last time, 0=I 1=D
//                           (this port exists only with ARB_ROUND_ROBIN_EN)
//   grant_i, grant_d   out  one-hot grant (both 0 when nothing requested)
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   : ties go to the side that did not win last time
//   undefined : ties always go to the D-side
// ----------------------------------------------------------------------------
module arb_grant_sel (
    input  logic i_req,
    input  logic d_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_grant,
`endif
    output logic grant_i,
    output logic grant_d
);

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_d = ~last_grant;
            grant_i = last_grant;
`else
            // A D-side miss stalls the pipeline, so it is served first.
            grant_d = 1'b1;
`endif
        end else begin
            grant_i = i_req;
            grant_d = d_req;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// ----------------------------------------------------------------------------
// cache_mem_arbiter
// Shares the single memory-side bus between the I-cache and D-cache
// miss/uncached ports. When the bus is idle, a winner is chosen and its
// command is latched. The latched command is driven to memory until m_ready
// is seen, and the read data/ready is returned to the owner. There is always
// one idle cycle between transfers.
// Parameters:
//   A_WIDTH        address width of both requesters and the memory port
// Ports:
//   clk, clrn      clock; synchronous active-low reset
//   i_* / d_*      requester side: a, din, strobe, wen, size, rw in;
//                  dout, ready out (ready is combinational with m_ready)
//   m_*            memory command out (a, din, strobe, wen, size, rw);
//                  m_dout, m_ready in
// Configuration macro: ARB_ROUND_ROBIN_EN (see arb_grant_sel). It adds the
// last_grant register.
// ----------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int unsigned A_WIDTH = 32
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [A_WIDTH-1:0] i_a,
    input  logic [31:0]        i_din,
    input  logic               i_strobe,
    input  logic [3:0]         i_wen,
    input  logic [1:0]         i_size,
    input  logic               i_rw,
    output logic [31:0]        i_dout,
    output logic               i_ready,
    input  logic [A_WIDTH-1:0] d_a,
    input  logic [31:0]        d_din,
    input  logic               d_strobe,
    input  logic [3:0]         d_wen,
    input  logic [1:0]         d_size,
    input  logic               d_rw,
    output logic [31:0]        d_dout,
    output logic               d_ready,
    output logic [A_WIDTH-1:0] m_a,
    output logic [31:0]        m_din,
    output logic               m_strobe,
    output logic [3:0]         m_wen,
    output logic [1:0]         m_size,
    output logic               m_rw,
    input  logic [31:0]        m_dout,
    input  logic               m_ready
);

    import cpu_bus_pkg::*;

    arb_state_t r_state;
    arb_state_t w_next_state;
    mem_req_t   r_cmd;
    mem_req_t   w_sel;
    logic       w_grant_i;
    logic       w_grant_d;
    logic       w_latch;
    logic       w_unused_addr;

`ifdef ARB_ROUND_ROBIN_EN
    logic       r_last_grant;   // 0 = I-side, 1 = D-side
`endif

    arb_grant_sel u_grant_sel (
        .i_req      (i_strobe),
        .d_req      (d_strobe),
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant (r_last_grant),
`endif
        .grant_i    (w_grant_i),
        .grant_d    (w_grant_d)
    );

    // Command of whichever side wins this cycle.
    always_comb begin
        w_sel = '0;
        if (w_grant_d) begin
            w_sel.addr  = ADDR_W_MAX'(d_a);
            w_sel.wdata = d_din;
            w_sel.wen   = d_wen;
            w_sel.size  = d_size;
            w_sel.rw    = d_rw;
        end else begin
            w_sel.addr  = ADDR_W_MAX'(i_a);
            w_sel.wdata = i_din;
            w_sel.wen   = i_wen;
            w_sel.size  = i_size;
            w_sel.rw    = i_rw;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and return path
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        m_strobe     = 1'b0;
        i_ready      = 1'b0;
        d_ready      = 1'b0;
        i_dout       = '0;
        d_dout       = '0;
        case (r_state)
            ARB_IDLE: begin
                // A stray m_ready here has no owner and is dropped.
                if (w_grant_d) begin
                    w_next_state = ARB_GRANT_D;
                    w_latch      = 1'b1;
                end else if (w_grant_i) begin
                    w_next_state = ARB_GRANT_I;
                    w_latch      = 1'b1;
                end
            end
            ARB_GRANT_I: begin
                m_strobe = 1'b1;
                i_dout   = m_dout;
                // A flushed requester (strobe dropped) still lets the bus
                // transfer finish, but it gets no ready pulse.
                i_ready  = m_ready & i_strobe;
                if (m_ready) begin
                    w_next_state = ARB_IDLE;
                end
            end
            ARB_GRANT_D: begin
                m_strobe = 1'b1;
                d_dout   = m_dout;
                d_ready  = m_ready & d_strobe;
                if (m_ready) begin
                    w_next_state = ARB_IDLE;
                end
            end
            default: begin
                w_next_state = ARB_IDLE;
            end
        endcase
    end

    // Command latch. The memory side sees only this register, so a
    // requester that changes its command while granted has no effect.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_cmd <= '0;
        end else if (w_latch) begin
            r_cmd <= w_sel;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_last_grant <= 1'b0;
        end else if (w_latch) begin
            r_last_grant <= w_grant_d;
        end
    end
`endif

    assign m_a    = r_cmd.addr[A_WIDTH-1:0];
    assign m_din  = r_cmd.wdata;
    assign m_wen  = r_cmd.wen;
    assign m_size = r_cmd.size;
    assign m_rw   = r_cmd.rw;

    // The address bits above A_WIDTH are always zero.
    assign w_unused_addr = ^r_cmd.addr;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cache_mem_arbiter
// This bench runs directed scenarios followed by randomized traffic. A
// transaction-level model inside the bench tracks who owns the bus and
// which command was latched. Every cycle, all DUT outputs are compared
// against that model.
// ----------------------------------------------------------------------------
module tb_cache_mem_arbiter;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          clrn;
    logic [AW-1:0] i_a, d_a, m_a;
    logic [31:0]   i_din, d_din, m_din, i_dout, d_dout, m_dout;
    logic          i_strobe, d_strobe, m_strobe;
    logic [3:0]    i_wen, d_wen, m_wen;
    logic [1:0]    i_size, d_size, m_size;
    logic          i_rw, d_rw, m_rw;
    logic          i_ready, d_ready, m_ready;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.A_WIDTH(AW)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .i_a      (i_a),
        .i_din    (i_din),
        .i_strobe (i_strobe),
        .i_wen    (i_wen),
        .i_size   (i_size),
        .i_rw     (i_rw),
        .i_dout   (i_dout),
        .i_ready  (i_ready),
        .d_a      (d_a),
        .d_din    (d_din),
        .d_strobe (d_strobe),
        .d_wen    (d_wen),
        .d_size   (d_size),
        .d_rw     (d_rw),
        .d_dout   (d_dout),
        .d_ready  (d_ready),
        .m_a      (m_a),
        .m_din    (m_din),
        .m_strobe (m_strobe),
        .m_wen    (m_wen),
        .m_size   (m_size),
        .m_rw     (m_rw),
        .m_dout   (m_dout),
        .m_ready  (m_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model. Owner encoding: 0 = bus free, 1 = I-side, 2 = D-side.
    int            mdl_owner;
    int            mdl_last;
    bit            mdl_valid = 1'b0;
    logic [AW-1:0] mdl_a;
    logic [31:0]   mdl_din;
    logic [3:0]    mdl_wen;
    logic [1:0]    mdl_size;
    logic          mdl_rw;

    task automatic check_outputs();
        check_eq("m_strobe", m_strobe, mdl_owner != 0);
        check_eq("m_a",      m_a,      mdl_a);
        check_eq("m_din",    m_din,    mdl_din);
        check_eq("m_wen",    m_wen,    mdl_wen);
        check_eq("m_size",   m_size,   mdl_size);
        check_eq("m_rw",     m_rw,     mdl_rw);
        check_eq("i_ready",  i_ready,  (mdl_owner == 1) && m_ready && i_strobe);
        check_eq("d_ready",  d_ready,  (mdl_owner == 2) && m_ready && d_strobe);
        check_eq("i_dout",   i_dout,   (mdl_owner == 1) ? m_dout : 32'h0);
        check_eq("d_dout",   d_dout,   (mdl_owner == 2) ? m_dout : 32'h0);
    endtask

    task automatic model_edge();
        int win;
        if (!clrn) begin
            mdl_owner = 0;
            mdl_last  = 1;
            mdl_a = '0; mdl_din = '0; mdl_wen = '0; mdl_size = '0; mdl_rw = 1'b0;
        end else if (mdl_owner == 0) begin
            if (i_strobe || d_strobe) begin
                if (i_strobe && d_strobe) begin
`ifdef ARB_ROUND_ROBIN_EN
                    win = (mdl_last == 2) ? 1 : 2;
`else
                    win = 2;
`endif
                end else begin
                    win = d_strobe ? 2 : 1;
                end
                mdl_owner = win;
                mdl_last  = win;
                if (win == 2) begin
                    mdl_a = d_a; mdl_din = d_din; mdl_wen = d_wen; mdl_size = d_size; mdl_rw = d_rw;
                end else begin
                    mdl_a = i_a; mdl_din = i_din; mdl_wen = i_wen; mdl_size = i_size; mdl_rw = i_rw;
                end
            end
        end else if (m_ready) begin
            mdl_owner = 0;
        end
        mdl_valid = 1'b1;
    endtask

    // Inputs are changed only just after a posedge. Outputs are checked on
    // the negedge, and the model advances at the posedge.
    task automatic cycle();
        @(negedge clk);
        if (mdl_valid) check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        i_strobe = 1'b0; d_strobe = 1'b0; m_ready = 1'b0; m_dout = '0;
    endtask

    logic [AW-1:0] exp_addr;

    initial begin
        clrn = 1'b0;
        i_a = '0; i_din = '0; i_wen = '0; i_size = '0; i_rw = 1'b0;
        d_a = '0; d_din = '0; d_wen = '0; d_size = '0; d_rw = 1'b0;
        idle_inputs();
        cycle();
        cycle();
        clrn = 1'b1;
        #1;
        check_eq("rst_m_strobe", m_strobe, 1'b0);
        check_eq("rst_m_a", m_a, '0);

        // Single I-side read
        i_a = 32'h1FC0_0000; i_rw = 1'b0; i_size = 2'd2; i_wen = 4'hF; i_strobe = 1'b1;
        cycle();
        #1;
        check_eq("t1_m_strobe", m_strobe, 1'b1);
        check_eq("t1_m_a", m_a, 32'h1FC0_0000);
        cycle();
        m_ready = 1'b1; m_dout = 32'hDEAD_BEEF;
        #1;
        check_eq("t1_i_ready", i_ready, 1'b1);
        check_eq("t1_i_dout", i_dout, 32'hDEAD_BEEF);
        check_eq("t1_d_ready", d_ready, 1'b0);
        cycle();
        idle_inputs();
        cycle();

        // Four ties. Fixed priority always picks D. Round robin alternates,
        // starting with D because I was the last side granted.
        i_a = 32'h0000_1000; d_a = 32'h0000_2000;
        for (int k = 0; k < 4; k++) begin
            i_strobe = 1'b1; d_strobe = 1'b1;
            cycle();
`ifdef ARB_ROUND_ROBIN_EN
            exp_addr = (k % 2 == 0) ? 32'h0000_2000 : 32'h0000_1000;
`else
            exp_addr = 32'h0000_2000;
`endif
            check_eq("t2_tie_winner", m_a, exp_addr);
            m_ready = 1'b1; m_dout = $urandom;
            cycle();
            idle_inputs();
            cycle();
        end

        // D-side write, with the command changed during the transfer
        d_a = 32'h8000_0010; d_din = 32'h1234_5678; d_wen = 4'b0011; d_size = 2'd1; d_rw = 1'b1;
        d_strobe = 1'b1;
        cycle();
        check_eq("t3_m_a", m_a, 32'h8000_0010);
        check_eq("t3_m_din", m_din, 32'h1234_5678);
        check_eq("t3_m_wen", m_wen, 4'b0011);
        check_eq("t3_m_size", m_size, 2'd1);
        check_eq("t3_m_rw", m_rw, 1'b1);
        d_din = 32'hFFFF_0000; d_a = 32'h0;
        cycle();
        check_eq("t3_m_din_held", m_din, 32'h1234_5678);
        m_ready = 1'b1;
        cycle();
        idle_inputs();
        cycle();

        // Flush: D drops its strobe while granted, and I is waiting
        d_a = 32'h8000_0040; d_rw = 1'b0; d_strobe = 1'b1;
        cycle();
        d_strobe = 1'b0; i_strobe = 1'b1; i_a = 32'h1FC0_0100;
        cycle();
        m_ready = 1'b1; m_dout = 32'hCAFE_F00D;
        #1;
        check_eq("t4_m_strobe_held", m_strobe, 1'b1);
        check_eq("t4_d_ready_orphan", d_ready, 1'b0);
        cycle();
        m_ready = 1'b0;
        #1;
        check_eq("t4_dead_idle", m_strobe, 1'b0);
        cycle();
        check_eq("t4_i_granted", m_a, 32'h1FC0_0100);
        m_ready = 1'b1;
        cycle();
        idle_inputs();
        cycle();

        // Reset during a transfer, then a stray m_ready while idle
        i_strobe = 1'b1; i_a = 32'h0000_0ABC;
        cycle();
        clrn = 1'b0;
        cycle();
        clrn = 1'b1; m_ready = 1'b1; m_dout = 32'h5555_AAAA;
        #1;
        check_eq("t5_m_strobe", m_strobe, 1'b0);
        check_eq("t5_i_ready", i_ready, 1'b0);
        i_strobe = 1'b0;
        cycle();
        idle_inputs();
        cycle();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if (!i_strobe) i_strobe = ($urandom_range(0, 99) < 30);
            else           i_strobe = ($urandom_range(0, 99) >= 10);
            if (!d_strobe) d_strobe = ($urandom_range(0, 99) < 30);
            else           d_strobe = ($urandom_range(0, 99) >= 10);
            i_a = $urandom; i_din = $urandom; i_wen = 4'($urandom); i_size = 2'($urandom); i_rw = 1'($urandom);
            d_a = $urandom; d_din = $urandom; d_wen = 4'($urandom); d_size = 2'($urandom); d_rw = 1'($urandom);
            m_ready = ($urandom_range(0, 99) < 35);
            m_dout  = $urandom;
            clrn    = ($urandom_range(0, 99) >= 2);
            cycle();
        end
        clrn = 1'b1;
        idle_inputs();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net in case the stimulus stops advancing
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule
